// File: rtl/marker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : marker_pkg
// Purpose  : Shared defaults, FSM state encoding and fixed division latency
//            for the marker centroid block and its sequential divider.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package marker_pkg;

  // Default widths used by marker_centroid / seq_divider parameters
  localparam int COORD_W_DFLT    = 11;
  localparam int CNT_W_DFLT      = 20;
  localparam int SUM_W_DFLT      = 31;
  localparam int MIN_PIXELS_DFLT = 4;

  // One load cycle plus one restoring iteration per dividend bit
  localparam int DIV_CYCLES = SUM_W_DFLT + 1;

  // Centroid sequencer states
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIV_X1 = 3'd1;
  localparam logic [2:0] S_DIV_Y1 = 3'd2;
  localparam logic [2:0] S_DIV_X2 = 3'd3;
  localparam logic [2:0] S_DIV_Y2 = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;

endpackage : marker_pkg
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Unsigned restoring divider, DVD_W-bit dividend by DVS_W-bit
//            divisor. Fixed latency: the start cycle loads the operands and
//            DVD_W further cycles each produce one quotient bit (MSB first).
// Ports    : clock      - system clock
//            reset      - synchronous active-low reset
//            i_start    - load operands and begin a division
//            i_dividend - dividend, sampled with i_start
//            i_divisor  - divisor, sampled with i_start
//            o_busy     - high for exactly DVD_W+1 cycles from i_start
//            o_done     - one-cycle pulse, o_quotient valid from this cycle
//            o_quotient - quotient (holds until next start)
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import marker_pkg::*;
#(
  parameter int DVD_W = SUM_W_DFLT,
  parameter int DVS_W = CNT_W_DFLT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int DCNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0]  r_rem;
  logic [DVD_W-1:0]  r_quo;   // dividend shifts out the top, quotient in the bottom
  logic [DVS_W-1:0]  r_dvs;
  logic [DCNT_W-1:0] r_cnt;
  logic              r_run;
  logic              r_done;

  logic [DVS_W:0]    w_shift;
  logic              w_ge;
  logic [DVS_W-1:0]  w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits
  // DVS_W+1 bits and the difference (when taken) fits DVS_W bits.
  assign w_shift = {r_rem, r_quo[DVD_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[DVS_W-1:0] - r_dvs;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= '0;
        r_quo <= i_dividend;
        r_dvs <= i_divisor;
        r_cnt <= DCNT_W'(DVD_W);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_ge ? w_diff : w_shift[DVS_W-1:0];
        r_quo <= {r_quo[DVD_W-2:0], w_ge};
        r_cnt <= r_cnt - DCNT_W'(1);
        if (r_cnt == DCNT_W'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // The load cycle counts as busy so the window is exactly DVD_W+1 cycles
  assign o_busy     = r_run | i_start;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule : seq_divider
`default_nettype wire

// File: rtl/marker_centroid.sv
`default_nettype none
// ============================================================================
// Module   : marker_centroid
// Purpose  : Accumulates per-pixel classifier hits for two hand markers over
//            a frame and, at frame end, computes each marker's mean position
//            with one time-shared sequential divider. Outputs update once per
//            frame, all together, with a pos_valid pulse a fixed
//            4*(SUM_W+1)+2 cycles after frame_end.
// Options  : CENTROID_SMOOTH_EN - when defined, tracked outputs follow
//            new = (3*old + q) >> 2 (first tracked frame loads q directly);
//            when undefined, new = q.
// Ports    : clock, reset          - clock, synchronous active-low reset
//            pixel_valid           - pix_x/pix_y/hit1/hit2 valid this cycle
//            pix_x, pix_y          - current pixel column / row
//            hit1, hit2            - pixel classified as marker 1 / marker 2
//            frame_end             - pulse after last active pixel of a frame
//            x1, y1, x2, y2        - marker centroids
//            pos_valid             - pulse when x1..y2 update
//            lost1, lost2          - marker below MIN_PIXELS last frame
//            busy                  - division sequence in progress
//            overrun               - pulse when a frame_end was dropped
// Revision : 1.0 - initial release
// ============================================================================
module marker_centroid
  import marker_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int SUM_W      = SUM_W_DFLT,
  parameter int MIN_PIXELS = MIN_PIXELS_DFLT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               hit1,
  input  logic               hit2,
  input  logic               frame_end,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic               pos_valid,
  output logic               lost1,
  output logic               lost2,
  output logic               busy,
  output logic               overrun
);

  localparam int DIV_CYC = SUM_W + 1;
  localparam int CYC_W   = $clog2(DIV_CYC);
  localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(DIV_CYC - 1);

  // --------------------------------------------------------------------------
  // Saturating helpers
  // --------------------------------------------------------------------------
  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0]   a,
                                                input logic [COORD_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - COORD_W){1'b0}}, b};
    sum_add = s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] a);
    cnt_inc = (&a) ? a : a + CNT_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Live accumulators
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] r_sx1, r_sy1, r_sx2, r_sy2;
  logic [CNT_W-1:0] r_n1, r_n2;
  logic [SUM_W-1:0] w_sx1_nxt, w_sy1_nxt, w_sx2_nxt, w_sy2_nxt;
  logic [CNT_W-1:0] w_n1_nxt, w_n2_nxt;

  // Hold registers (snapshot of the closed frame)
  logic [SUM_W-1:0] r_hsx1, r_hsy1, r_hsx2, r_hsy2;
  logic [CNT_W-1:0] r_hn1, r_hn2;

  // Sequencer
  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [1:0]       r_qidx;
  logic [COORD_W-1:0] r_qx1, r_qy1, r_qx2, r_qy2;
  logic             r_overrun;
  logic             r_pos_valid;

  logic             w_close;
  logic             w_start;
  logic [SUM_W-1:0] w_dividend;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_divisor;
  logic [SUM_W-1:0] w_quo;
  logic [COORD_W-1:0] w_qsat;
  logic             w_div_done;
  logic             w_div_busy;
  logic             w_trk1, w_trk2;
  logic [COORD_W-1:0] w_nx1, w_ny1, w_nx2, w_ny2;

  // Next live values include this cycle's pixel, so a pixel coincident with
  // frame_end lands in the snapshot of the closing frame.
  always_comb begin
    w_sx1_nxt = r_sx1;
    w_sy1_nxt = r_sy1;
    w_n1_nxt  = r_n1;
    w_sx2_nxt = r_sx2;
    w_sy2_nxt = r_sy2;
    w_n2_nxt  = r_n2;
    if (pixel_valid && hit1) begin
      w_sx1_nxt = sum_add(r_sx1, pix_x);
      w_sy1_nxt = sum_add(r_sy1, pix_y);
      w_n1_nxt  = cnt_inc(r_n1);
    end
    if (pixel_valid && hit2) begin
      w_sx2_nxt = sum_add(r_sx2, pix_x);
      w_sy2_nxt = sum_add(r_sy2, pix_y);
      w_n2_nxt  = cnt_inc(r_n2);
    end
  end

  assign w_close = frame_end && (r_state == S_IDLE);

  // Any frame_end (accepted or dropped) restarts accumulation from zero
  always_ff @(posedge clock) begin
    if (!reset || frame_end) begin
      r_sx1 <= '0;
      r_sy1 <= '0;
      r_n1  <= '0;
      r_sx2 <= '0;
      r_sy2 <= '0;
      r_n2  <= '0;
    end else begin
      r_sx1 <= w_sx1_nxt;
      r_sy1 <= w_sy1_nxt;
      r_n1  <= w_n1_nxt;
      r_sx2 <= w_sx2_nxt;
      r_sy2 <= w_sy2_nxt;
      r_n2  <= w_n2_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hsx1 <= '0;
      r_hsy1 <= '0;
      r_hn1  <= '0;
      r_hsx2 <= '0;
      r_hsy2 <= '0;
      r_hn2  <= '0;
    end else if (w_close) begin
      r_hsx1 <= w_sx1_nxt;
      r_hsy1 <= w_sy1_nxt;
      r_hn1  <= w_n1_nxt;
      r_hsx2 <= w_sx2_nxt;
      r_hsy2 <= w_sy2_nxt;
      r_hn2  <= w_n2_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Divider operand select and start
  // --------------------------------------------------------------------------
  assign w_trk1 = (r_hn1 >= CNT_W'(MIN_PIXELS));
  assign w_trk2 = (r_hn2 >= CNT_W'(MIN_PIXELS));

  always_comb begin
    w_dividend = '0;
    w_n        = '0;
    w_start    = 1'b0;
    case (r_state)
      S_DIV_X1: begin w_dividend = r_hsx1; w_n = r_hn1; w_start = (r_cyc == '0); end
      S_DIV_Y1: begin w_dividend = r_hsy1; w_n = r_hn1; w_start = (r_cyc == '0); end
      S_DIV_X2: begin w_dividend = r_hsx2; w_n = r_hn2; w_start = (r_cyc == '0); end
      S_DIV_Y2: begin w_dividend = r_hsy2; w_n = r_hn2; w_start = (r_cyc == '0); end
      default:  begin w_dividend = '0;     w_n = '0;    w_start = 1'b0;          end
    endcase
  end

  // Untracked markers still divide (by 1) to keep the latency data-independent
  assign w_divisor = (w_n >= CNT_W'(MIN_PIXELS)) ? w_n : CNT_W'(1);

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  assign w_qsat = (|w_quo[SUM_W-1:COORD_W]) ? {COORD_W{1'b1}} : w_quo[COORD_W-1:0];

  // --------------------------------------------------------------------------
  // Sequencer: four DIV_CYC-cycle division slots, then a two-cycle UPDATE
  // (cycle 0 collects the last quotient, cycle 1 publishes).
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cyc <= '0;
          if (frame_end) r_state <= S_DIV_X1;
        end
        S_DIV_X1, S_DIV_Y1, S_DIV_X2, S_DIV_Y2: begin
          if (r_cyc == C_CYC_LAST) begin
            r_cyc <= '0;
            case (r_state)
              S_DIV_X1: r_state <= S_DIV_Y1;
              S_DIV_Y1: r_state <= S_DIV_X2;
              S_DIV_X2: r_state <= S_DIV_Y2;
              default:  r_state <= S_UPDATE;
            endcase
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        S_UPDATE: begin
          if (r_cyc == '0) begin
            r_cyc <= CYC_W'(1);
          end else begin
            r_cyc   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= '0;
        end
      endcase
    end
  end

  // Quotients arrive in X1, Y1, X2, Y2 order, one done pulse each
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_qidx <= '0;
      r_qx1  <= '0;
      r_qy1  <= '0;
      r_qx2  <= '0;
      r_qy2  <= '0;
    end else begin
      if (r_state == S_IDLE) r_qidx <= '0;
      if (w_div_done) begin
        case (r_qidx)
          2'd0:    r_qx1 <= w_qsat;
          2'd1:    r_qy1 <= w_qsat;
          2'd2:    r_qx2 <= w_qsat;
          default: r_qy2 <= w_qsat;
        endcase
        r_qidx <= r_qidx + 2'd1;
      end
    end
  end

`ifdef CENTROID_SMOOTH_EN
  function automatic logic [COORD_W-1:0] f_smooth(input logic [COORD_W-1:0] old,
                                                   input logic [COORD_W-1:0] q,
                                                   input logic               first);
    logic [COORD_W+1:0] acc;
    acc      = {2'b00, old} + {1'b0, old, 1'b0} + {2'b00, q};
    f_smooth = first ? q : COORD_W'(acc >> 2);
  endfunction

  // A marker coming back from lost (or out of reset) restarts the filter
  assign w_nx1 = f_smooth(x1, r_qx1, lost1);
  assign w_ny1 = f_smooth(y1, r_qy1, lost1);
  assign w_nx2 = f_smooth(x2, r_qx2, lost2);
  assign w_ny2 = f_smooth(y2, r_qy2, lost2);
`else
  assign w_nx1 = r_qx1;
  assign w_ny1 = r_qy1;
  assign w_nx2 = r_qx2;
  assign w_ny2 = r_qy2;
`endif

  // Published outputs change together, only in the final UPDATE cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      y2          <= '0;
      lost1       <= 1'b1;
      lost2       <= 1'b1;
      r_pos_valid <= 1'b0;
    end else begin
      r_pos_valid <= 1'b0;
      if ((r_state == S_UPDATE) && (r_cyc != '0)) begin
        r_pos_valid <= 1'b1;
        if (w_trk1) begin
          x1    <= w_nx1;
          y1    <= w_ny1;
          lost1 <= 1'b0;
        end else begin
          lost1 <= 1'b1;
        end
        if (w_trk2) begin
          x2    <= w_nx2;
          y2    <= w_ny2;
          lost2 <= 1'b0;
        end else begin
          lost2 <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= frame_end && (r_state != S_IDLE);
    end
  end

  assign pos_valid = r_pos_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE) || w_div_busy;

endmodule : marker_centroid
`default_nettype wire

// File: doc/marker_centroid.md
Name: marker_centroid

Overview:
- Upstream stage of the gesture off-detection FSM. Consumes the per-pixel colour-classifier hits for two hand markers over one video frame.
- Accumulates coordinate sums and pixel counts per marker. At frame end, computes the mean position of each marker with a shared sequential divider.
- Presents x1/y1/x2/y2 as stable 11-bit registers, updated once per frame, which feed the gesture FSMs directly.

Parameters:
- COORD_W, 11, width of pixel coordinates and output positions
- CNT_W, 20, width of per-marker pixel counters (≥ log2 of active pixels per frame)
- SUM_W, 31, width of coordinate-sum accumulators
- MIN_PIXELS, 4, minimum hit count for a marker to be considered tracked

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pixel_valid  in  1  pix_x/pix_y/hit1/hit2 valid this cycle
- pix_x  in  COORD_W  current pixel column
- pix_y  in  COORD_W  current pixel row
- hit1  in  1  pixel classified as marker 1
- hit2  in  1  pixel classified as marker 2
- frame_end  in  1  single-cycle pulse after the last active pixel of a frame
- x1, y1, x2, y2  out  COORD_W each  marker centroids
- pos_valid  out  1  one-cycle pulse when x1..y2 update
- lost1, lost2  out  1 each  marker below MIN_PIXELS in last computed frame
- busy  out  1  divider sequence in progress
- overrun  out  1  one-cycle pulse when a frame_end is dropped

Behaviour:
- Reset: reset is sampled on the rising clock edge; reset==0 forces x1..y2=0, lost1=lost2=1, pos_valid=0, busy=0, overrun=0, all accumulators=0, FSM=IDLE. Reset mid-division aborts the sequence with no pos_valid.
- Accumulation, on pixel_valid:
  - hit1: sx1+=pix_x, sy1+=pix_y, n1+=1. hit2: the same into the marker-2 set. hit1 and hit2 may both be set.
  - Counters saturate at all-ones and never wrap.
- Frame close: frame_end is sampled while FSM=IDLE.
  - Snapshot {sx1,sy1,n1,sx2,sy2,n2} into hold registers; clear the live accumulators the same cycle.
  - A pixel_valid coincident with frame_end is counted into the closing frame.
- FSM states: IDLE -> DIV_X1 -> DIV_Y1 -> DIV_X2 -> DIV_Y2 -> UPDATE -> IDLE.
  - Each DIV state takes exactly SUM_W+1 cycles: 1 load cycle plus SUM_W restoring iterations.
  - busy=1 in all states except IDLE.
- Latency: pos_valid is high exactly 4*(SUM_W+1)+2 cycles after the frame_end edge, which is 130 cycles at the defaults. Latency is fixed regardless of data.
- Divide-by-zero and low counts:
  - If n<MIN_PIXELS, the divider still runs (divisor forced to 1), but the result is discarded.
  - That marker's outputs hold their previous values and its lost flag is set. Otherwise lost is cleared.
- Quotient: truncated (floor). Saturates to all-ones if it exceeds COORD_W bits.
- UPDATE: all four outputs and lost flags change in the same cycle as pos_valid. Outputs are never partially updated.
- Overrun: a frame_end while busy=1 is dropped and overrun pulses the next cycle. The live accumulators are still cleared, so the next frame starts fresh.

Optional Feature:
- Macro: CENTROID_SMOOTH_EN.
- Defined: each tracked output updates as new_out = (3*old + q) >> 2, using COORD_W+2-bit intermediate arithmetic. The first tracked frame after reset or after lost loads q directly.
- Undefined: new_out = q.
- Latency and the pos_valid timing are identical in both builds.

Decomposition:
- Shared package marker_pkg: COORD_W, CNT_W, SUM_W defaults; FSM state enum; the fixed-latency constant DIV_CYCLES = SUM_W+1.
- One sub-module: seq_divider.
  - Restoring, unsigned SUM_W/CNT_W.
  - Interface: start, done, quotient; busy for exactly DIV_CYCLES.
  - Instantiated once and time-shared across the four divisions.

Test Plan:
- Single frame with hit1 at (7,12) and hit2 at (13,12), MIN_PIXELS=1 -> 130 cycles after frame_end: pos_valid=1, x1=7, y1=12, x2=13, y2=12, lost1=lost2=0.
- hit1 on (10,20),(11,20),(10,21),(11,21) -> x1=10, y1=20 (floor of 10.5/20.5), lost1=0.
- Frame with 2 hit2 pixels, MIN_PIXELS=4, previous x2=13 -> lost2=1, x2 holds 13, x1/y1 still update.
- Second frame_end 50 cycles after the first -> overrun pulses once, only one pos_valid, results from the first frame.
- reset=0 at cycle 60 of division -> x1..y2=0, lost1=lost2=1, no pos_valid; the next full frame computes normally.
- CENTROID_SMOOTH_EN defined, x1 previously 100, next frame mean 200 -> x1=125.
